// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_ctrl: stall/flush controller with a multi-cycle EX sequencer.     |
// | Optional flush support: PIPELINE_CTRL_FLUSH_EN.  Revision 1.0              |
// +----------------------------------------------------------------------------+
module pipeline_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       stallreq_id,
   input  logic       ex_mc_start,
   input  logic [5:0] ex_mc_cycles,
   input  logic       flush_req,
   output logic [5:0] stall,
   output logic       ex_mc_busy,
   output logic       ex_mc_done,
   output logic [5:0] mc_count,
   output logic       flush
);

   localparam logic [5:0] C_STALL_NONE = 6'b000000;
   localparam logic [5:0] C_STALL_ID   = 6'b000111;
   localparam logic [5:0] C_STALL_EX   = 6'b001111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [5:0] r_count;
   logic [5:0] w_count_nxt;
   logic       w_flush_req;

`ifdef PIPELINE_CTRL_FLUSH_EN
   logic r_flush;

   assign w_flush_req = flush_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush <= 1'b0;
      end else begin
         r_flush <= flush_req;
      end
   end

   assign flush = r_flush;
`else
   logic w_unused_flush_req;

   assign w_unused_flush_req = flush_req;
   assign w_flush_req        = 1'b0;
   assign flush              = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= 6'd0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      case (r_state)
         S_IDLE: begin
            if (ex_mc_start) begin
               w_state_nxt = S_BUSY;
               // A zero-length request still occupies EX for one cycle.
               w_count_nxt = (ex_mc_cycles == 6'd0) ? 6'd1 : ex_mc_cycles;
            end
         end
         S_BUSY: begin
            if (r_count == 6'd1) begin
               w_state_nxt = S_DONE;
               w_count_nxt = 6'd0;
            end else begin
               w_count_nxt = r_count - 6'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = 6'd0;
         end
      endcase

      if (w_flush_req) begin
         w_state_nxt = S_IDLE;
         w_count_nxt = 6'd0;
      end
   end

   // DONE releases EX so EX/MEM captures the multi-cycle result that cycle.
   always_comb begin
      stall = C_STALL_NONE;
      if (rst || w_flush_req) begin
         stall = C_STALL_NONE;
      end else if ((r_state == S_IDLE && ex_mc_start) || r_state == S_BUSY) begin
         stall = C_STALL_EX;
      end else if (stallreq_id) begin
         stall = C_STALL_ID;
      end
   end

   assign ex_mc_busy = (r_state == S_BUSY);
   assign ex_mc_done = (r_state == S_DONE);
   assign mc_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// Randomized bench for pipeline_ctrl; the reference tracks each accepted op
// as (start cycle, length) and derives every output from cycle arithmetic.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif
   localparam int NCYC = 900;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stallreq_id = 1'b0;
   logic       ex_mc_start = 1'b0;
   logic [5:0] ex_mc_cycles = 6'd0;
   logic       flush_req = 1'b0;
   logic [5:0] stall;
   logic       ex_mc_busy;
   logic       ex_mc_done;
   logic [5:0] mc_count;
   logic       flush;

   pipeline_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .ex_mc_start  (ex_mc_start),
      .ex_mc_cycles (ex_mc_cycles),
      .flush_req    (flush_req),
      .stall        (stall),
      .ex_mc_busy   (ex_mc_busy),
      .ex_mc_done   (ex_mc_done),
      .mc_count     (mc_count),
      .flush        (flush)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Reference state: one outstanding op described by when it started and how long it runs.
   bit op_act  = 1'b0;
   int op_t    = 0;
   int op_n    = 0;
   bit flush_q = 1'b0;
   int cyc     = 0;

   initial begin
      int  d;
      bit  e_busy, e_done, e_ex;
      int  e_cnt;
      logic [5:0] e_stall;
      bit  idle_now;

      for (int i = 0; i < NCYC; i++) begin
         #1;
         // Directed prologue, then random traffic.
         rst = 1'b0; ex_mc_start = 1'b0; ex_mc_cycles = 6'd0;
         stallreq_id = 1'b0; flush_req = 1'b0;
         if (i < 2) begin
            rst = 1'b1;
            ex_mc_start = 1'b1;
            ex_mc_cycles = 6'd3;
            stallreq_id = 1'b1;
         end else if (i < 40) begin
            case (i)
               3:  begin ex_mc_start = 1'b1; ex_mc_cycles = 6'd5; end
               5:  begin ex_mc_start = 1'b1; ex_mc_cycles = 6'd9; end
               6:  stallreq_id = 1'b1;
               9:  begin ex_mc_start = 1'b1; ex_mc_cycles = 6'd4; stallreq_id = 1'b1; end
               12: begin ex_mc_start = 1'b1; ex_mc_cycles = 6'd0; end
               16: begin ex_mc_start = 1'b1; ex_mc_cycles = 6'd7; end
               21: begin rst = 1'b1; ex_mc_start = 1'b1; end
               22: begin ex_mc_start = 1'b1; ex_mc_cycles = 6'd4; end
               24: flush_req = 1'b1;
               30: begin ex_mc_start = 1'b1; ex_mc_cycles = 6'd2; flush_req = 1'b1; end
               33: stallreq_id = 1'b1;
               default: ;
            endcase
         end else begin
            rst          = ($urandom_range(0, 59) == 0);
            ex_mc_start  = ($urandom_range(0, 3) == 0);
            ex_mc_cycles = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                      : 6'($urandom_range(0, 8));
            stallreq_id  = ($urandom_range(0, 2) == 0);
            flush_req    = ($urandom_range(0, 14) == 0);
         end

         @(negedge clk);
         d        = cyc - op_t;
         e_busy   = op_act && d >= 1 && d <= op_n;
         e_done   = op_act && d == op_n + 1;
         e_cnt    = e_busy ? (op_n - d + 1) : 0;
         e_ex     = (!op_act && ex_mc_start) || e_busy;
         e_stall  = 6'b000000;
         if (!(FLUSH_EN && flush_req)) begin
            if (e_ex)             e_stall = 6'b001111;
            else if (stallreq_id) e_stall = 6'b000111;
         end
         if (rst) begin
            e_busy = 1'b0; e_done = 1'b0; e_cnt = 0; e_stall = 6'b000000;
         end
         chk("stall",    32'(stall),      32'(e_stall));
         chk("busy",     32'(ex_mc_busy), 32'(e_busy));
         chk("done",     32'(ex_mc_done), 32'(e_done));
         chk("mc_count", 32'(mc_count),   32'(e_cnt));
         chk("flush",    32'(flush),      32'(rst ? 1'b0 : flush_q));

         @(posedge clk);
         d        = cyc - op_t;
         idle_now = !op_act;
         if (rst) begin
            op_act  = 1'b0;
            flush_q = 1'b0;
         end else begin
            flush_q = FLUSH_EN && flush_req;
            if (FLUSH_EN && flush_req) begin
               op_act = 1'b0;
            end else if (op_act && d == op_n + 1) begin
               op_act = 1'b0;
            end else if (idle_now && ex_mc_start) begin
               op_act = 1'b1;
               op_t   = cyc;
               op_n   = (ex_mc_cycles == 6'd0) ? 1 : int'(ex_mc_cycles);
            end
         end
         cyc++;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (async active-high reset).
REQ-002 Ports (name direction width meaning):
- stallreq_id input 1: ID load-use stall request.
- ex_mc_start input 1: EX issues a multi-cycle op (mult/div); single-cycle pulse.
- ex_mc_cycles input 6: op length N, sampled with ex_mc_start.
- flush_req input 1: exception/redirect flush request.
- stall output 6: per-stage hold; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved.
- ex_mc_busy output 1: multi-cycle op in progress.
- ex_mc_done output 1: one-cycle pulse, multi-cycle result valid.
- mc_count output 6: remaining cycles of the current op.
- flush output 1: one-cycle registered flush to all pipeline registers.

Function
REQ-003 FSM states SHALL be IDLE, BUSY and DONE.
REQ-004 In IDLE with ex_mc_start=1, the FSM SHALL go to BUSY and load mc_count with ex_mc_cycles; a value of 0 SHALL be loaded as 1.
REQ-005 In BUSY, mc_count SHALL decrement by 1 per cycle; when mc_count=1 the FSM SHALL go to DONE next cycle, with mc_count=0.
REQ-006 DONE SHALL last exactly one cycle with ex_mc_done=1, then return to IDLE.
REQ-007 ex_mc_start SHALL be ignored in BUSY and DONE; in DONE a new start SHALL NOT be accepted until IDLE.
REQ-008 Timing: start at cycle T, ex_mc_busy=1 for cycles T+1..T+N, ex_mc_done=1 at T+N+1.
REQ-009 stall SHALL be combinational from state and inputs, with priority flush > EX > ID.
REQ-010 EX stall (6'b001111) SHALL be driven in the start cycle (IDLE and ex_mc_start) and in every BUSY cycle.
REQ-011 ID stall (6'b000111) SHALL be driven when stallreq_id=1 and no EX stall applies; otherwise stall SHALL be 6'b000000.
REQ-012 In DONE, stall SHALL depend only on stallreq_id, so EX/MEM captures the result that cycle.
REQ-013 Bit5 of stall SHALL always be 0.
REQ-014 A stage held while the next stage is not held SHALL imply a bubble into the next register; the pipeline registers implement the bubble, and this block SHALL only issue the vector.

Reset
REQ-015 While rst=1: FSM IDLE, mc_count=0, ex_mc_busy=0, ex_mc_done=0, flush=0, stall=6'b000000, independent of other inputs.
REQ-016 Reset asserted mid-operation SHALL abort the op immediately; no ex_mc_done SHALL follow.
REQ-017 On the first edge after rst deasserts, the block SHALL accept ex_mc_start.

Configuration
REQ-018 The macro PIPELINE_CTRL_FLUSH_EN SHALL enable flush support.
REQ-019 With PIPELINE_CTRL_FLUSH_EN defined, flush_req=1 SHALL:
- register flush=1 for the next cycle;
- force the FSM to IDLE and mc_count to 0 at that edge;
- suppress any ex_mc_done that would have occurred;
- drive stall=0 in the flush_req cycle;
- override an ex_mc_start in the same cycle, so no op is accepted.
REQ-020 Without the macro, flush SHALL be tied 0, flush_req SHALL be ignored, and no flush logic SHALL be present.

Verification
REQ-021 Start with cycles=5 at T -> stall=001111 T..T+5; busy T+1..T+5; mc_count 5,4,3,2,1; done=1 only at T+6.
REQ-022 Start with cycles=0 -> busy for 1 cycle; done at T+2.
REQ-023 stallreq_id=1 during BUSY -> stall=001111; in the DONE cycle -> stall=000111.
REQ-024 Second start during BUSY, and a start in the DONE cycle -> both ignored; mc_count unaffected.
REQ-025 rst pulsed with mc_count=3 -> all outputs 0 immediately; no done pulse afterwards.
REQ-026 With FLUSH_EN, flush_req during BUSY -> flush=1 next cycle, FSM IDLE, no done; without FLUSH_EN -> op completes normally and flush stays 0.
